// File: rtl/mips_cpu_div_seq.sv
// ---------------------------------------------------------------------------
// mips_cpu_div_seq
// Multi-cycle restoring divider for DIV / DIVU. One quotient bit is produced
// per cycle. Results land in registered quotient (LO) / remainder (HI).
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_start         request, sampled only while idle
//   i_is_signed     1 = signed (DIV), 0 = unsigned (DIVU); captured with start
//   i_dividend      numerator, captured with start
//   i_divisor       denominator, captured with start
//   o_busy          high while an operation is in flight (RUN/FIX/DONE)
//   o_done          one-cycle pulse when results are valid
//   o_quotient      LO result, registered
//   o_remainder     HI result, registered
//   o_div_by_zero   flag for the last completed operation
// ---------------------------------------------------------------------------
module mips_cpu_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;        // |dividend|, shifted left each iteration
  logic [WIDTH-1:0] r_b;        // |divisor|
  logic [WIDTH-1:0] r_rem;      // partial remainder magnitude
  logic [WIDTH-1:0] r_q;        // quotient magnitude
  logic [WIDTH-1:0] r_dvd;      // original dividend, returned on divide-by-zero
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_b_zero;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  // Operand magnitudes. Negating MIN yields MIN, which read as unsigned is the
  // correct magnitude 2^(WIDTH-1).
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_a_neg = i_is_signed & i_dividend[WIDTH-1];
  assign w_b_neg = i_is_signed & i_divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;

  // Restoring step. The shifted remainder keeps its full WIDTH+1 bits: for
  // unsigned divisors above 2^(WIDTH-1) the partial remainder can have its
  // MSB set, and dropping it would corrupt the trial.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;

  assign w_shift    = {r_rem, r_a[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  // When w_ge holds the difference is below |b|, so WIDTH bits suffice.
  assign w_diff     = w_shift[WIDTH-1:0] - r_b;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];

  // Sign fix-up and divide-by-zero override.
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_q_fix = r_b_zero ? {WIDTH{1'b1}} : (r_sign_q ? (~r_q + 1'b1) : r_q);
  assign w_r_fix = r_b_zero ? r_dvd : (r_sign_r ? (~r_rem + 1'b1) : r_rem);

  // Next-state logic. RUN spends one extra cycle at count zero before FIX,
  // giving a fixed WIDTH+2 edge latency from acceptance to done.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvd       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_b_zero    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a      <= w_a_mag;
            r_b      <= w_b_mag;
            r_dvd    <= i_dividend;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_b_zero <= (i_divisor == '0);
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= CNT_W'(WIDTH);
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_rem <= w_rem_next;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
            r_a   <= {r_a[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_dbz       <= r_b_zero;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mips_cpu_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_div_seq
// Scoreboard bench for a 32-bit and an 8-bit divider instance. Drivers push
// the expected result of each accepted operation; monitors pop and compare
// on every done pulse, including latency and busy duration.
// ---------------------------------------------------------------------------
module tb_mips_cpu_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s32, sg32;
  logic [31:0] a32, b32;
  logic        busy32, done32, z32;
  logic [31:0] q32, r32;

  logic        s8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, z8;
  logic [7:0]  q8, r8;

  mips_cpu_div_seq #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32), .i_is_signed(sg32),
    .i_dividend(a32), .i_divisor(b32), .o_busy(busy32), .o_done(done32),
    .o_quotient(q32), .o_remainder(r32), .o_div_by_zero(z32)
  );

  mips_cpu_div_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_is_signed(sg8),
    .i_dividend(a8), .i_divisor(b8), .o_busy(busy8), .o_done(done8),
    .o_quotient(q8), .o_remainder(r8), .o_div_by_zero(z8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        sg, z;
    int          acc;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t m32_e, m8_e;
  int   bc32 = 0, bc8 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder
  // following the dividend; all-ones / dividend on a zero divisor.
  function automatic void model(input int w, input logic sg, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint sa, sd, tq, tr;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (b == 32'd0) begin
      q = mask; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (sg) begin
        sa = longint'(a);
        sd = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sd = sd - (longint'(1) << w);
        tq = sa / sd;
        tr = sa % sd;
        q = 32'(tq) & mask;
        r = 32'(tr) & mask;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic issue32(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy32 && n < 200) begin @(negedge clk); n++; end
    if (busy32) begin chk("wait_idle32", 64'(busy32), 64'd0); return; end
    sg32 = sg; a32 = a; b32 = b; s32 = 1'b1;
    e.a = a; e.b = b; e.sg = sg;
    model(32, sg, a, b, e.q, e.r, e.z);
    @(posedge clk); #1;
    e.acc = cyc;
    sb32.push_back(e);
    @(negedge clk);
    s32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = 1'($urandom);
  endtask

  task automatic issue8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 200) begin @(negedge clk); n++; end
    if (busy8) begin chk("wait_idle8", 64'(busy8), 64'd0); return; end
    sg8 = sg; a8 = a; b8 = b; s8 = 1'b1;
    e.a = {24'd0, a}; e.b = {24'd0, b}; e.sg = sg;
    model(8, sg, e.a, e.b, e.q, e.r, e.z);
    @(posedge clk); #1;
    e.acc = cyc;
    sb8.push_back(e);
    @(negedge clk);
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
  endtask

  task automatic wait_done32();
    int n = 0;
    while (!done32 && n < 100) begin @(negedge clk); n++; end
    if (!done32) chk("done32_timeout", 64'(done32), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0 || busy32 || busy8) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain32", 64'(sb32.size()), 64'd0);
    chk("drain8", 64'(sb8.size()), 64'd0);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst) begin
      bc32 = 0;
    end else begin
      if (busy32) bc32++;
      if (done32) begin
        if (sb32.size() == 0) begin
          chk("unexpected_done32", 64'(done32), 64'd0);
        end else begin
          m32_e = sb32.pop_front();
          $display("w32 sg=%0d a=%h b=%h -> q=%h r=%h dbz=%0d", m32_e.sg, m32_e.a, m32_e.b, q32, r32, z32);
          chk("q32", 64'(q32), 64'(m32_e.q));
          chk("r32", 64'(r32), 64'(m32_e.r));
          chk("dbz32", 64'(z32), 64'(m32_e.z));
          chk("latency32", 64'(cyc - m32_e.acc), 64'd34);
          chk("busy_len32", 64'(bc32), 64'd35);
        end
        bc32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        if (sb8.size() == 0) begin
          chk("unexpected_done8", 64'(done8), 64'd0);
        end else begin
          m8_e = sb8.pop_front();
          $display("w8 sg=%0d a=%h b=%h -> q=%h r=%h dbz=%0d", m8_e.sg, m8_e.a[7:0], m8_e.b[7:0], q8, r8, z8);
          chk("q8", 64'(q8), 64'(m8_e.q));
          chk("r8", 64'(r8), 64'(m8_e.r));
          chk("dbz8", 64'(z8), 64'(m8_e.z));
          chk("latency8", 64'(cyc - m8_e.acc), 64'd10);
          chk("busy_len8", 64'(bc8), 64'd11);
        end
        bc8 = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    s32 = 0; sg32 = 0; a32 = 0; b32 = 0;
    s8 = 0;  sg8 = 0;  a8 = 0;  b8 = 0;
    #1;
    chk("reset_busy32", 64'(busy32), 64'd0);
    chk("reset_done32", 64'(done32), 64'd0);
    chk("reset_q32", 64'(q32), 64'd0);
    chk("reset_r32", 64'(r32), 64'd0);
    chk("reset_dbz32", 64'(z32), 64'd0);
    chk("reset_q8", 64'(q8), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    issue32(1'b0, 32'd100, 32'd7);
    issue32(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue32(1'b1, 32'd7, 32'hFFFF_FFFE);
    issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue32(1'b0, 32'd5, 32'd0);
    issue32(1'b1, 32'hFFFF_FFFB, 32'd0);
    issue32(1'b0, 32'd6, 32'd3);
    issue32(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);

    // start while busy is ignored
    issue32(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    s32 = 1'b1; sg32 = 1'b0; a32 = 32'd1234; b32 = 32'd5;
    @(negedge clk);
    s32 = 1'b0;

    // start in the DONE cycle is ignored
    wait_done32();
    s32 = 1'b1; sg32 = 1'b0; a32 = 32'd55; b32 = 32'd5;
    @(negedge clk);
    s32 = 1'b0;

    issue8(1'b0, 8'd200, 8'd3);
    issue8(1'b1, 8'h80, 8'hFF);
    issue8(1'b1, 8'hF9, 8'h02);
    issue8(1'b0, 8'd17, 8'd0);

    // Randomized traffic on both instances
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int k;
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      k = $urandom_range(0, 9);
      if (k == 0)      b = 32'd0;
      else if (k < 4)  b = $urandom_range(1, 15);
      else if (k == 4) b = 32'hFFFF_FFFF;
      else             b = $urandom;
      issue32(1'($urandom), a, b);
    end
    for (int i = 0; i < 30; i++) begin
      issue8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));
    end
    drain();

    // Reset mid-RUN: outputs clear at once, no done pulse follows
    issue32(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy32", 64'(busy32), 64'd0);
    chk("midrst_done32", 64'(done32), 64'd0);
    chk("midrst_q32", 64'(q32), 64'd0);
    chk("midrst_r32", 64'(r32), 64'd0);
    chk("midrst_dbz32", 64'(z32), 64'd0);
    sb32.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue32(1'b0, 32'd9, 32'd4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
